rf_dump_reader: RTL and testbench

RF_DUMP_READER -- requirements
Module: rf_dump_reader

---
 rtl/rf_dump_pkg.sv | 15 +
 rtl/rf_dump_reader.sv | 101 ++++++++++
 tb/tb_rf_dump_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared types and widths for the register-file dump reader.
// Holds the FSM state encoding and address/data widths.
package rf_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_PRESENT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks register indices FIRST_IDX..LAST_IDX and presents each value on a
// valid/ready stream.
// Ports: clk, rst_n (async, active low); start, abort (control);
// rf_raddr/rf_rdata (register-file read port);
// out_valid/out_ready/out_data/out_idx (output stream); busy, done (status).
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int FIRST_IDX = 0,
  parameter int LAST_IDX  = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]       rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST = REG_ADDR_W'(FIRST_IDX);
  localparam logic [REG_ADDR_W-1:0] LAST  = REG_ADDR_W'(LAST_IDX);

  state_e                  state;
  state_e                  state_nxt;
  logic [REG_ADDR_W-1:0]   idx;
  logic [REG_ADDR_W-1:0]   idx_nxt;
  logic                    cap;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cap       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_READ;
          idx_nxt   = FIRST;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          idx_nxt   = FIRST;
        end else begin
          cap       = 1'b1;
          state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // abort beats a same-cycle handshake
        if (abort) begin
          state_nxt = ST_IDLE;
          idx_nxt   = FIRST;
        end else if (out_ready) begin
          if (idx == LAST) begin
            state_nxt = ST_DONE;
            idx_nxt   = FIRST;
          end else begin
            state_nxt = ST_READ;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= FIRST;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cap) begin
        out_data <= rf_rdata;
        out_idx  <= idx;
      end
    end
  end

  assign rf_raddr  = idx;
  assign out_valid = (state == ST_PRESENT);
  assign busy      = (state == ST_READ) || (state == ST_PRESENT);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed self-checking bench for rf_dump_reader.
// Three instances cover the full range, a 5..7 window and a 31..31 window.
module tb_rf_dump_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // instance A: 0..31
  logic        start_a = 0, abort_a = 0, ready_a = 0;
  logic [4:0]  raddr_a, idx_a;
  logic [31:0] rdata_a, data_a;
  logic        valid_a, busy_a, done_a;
  assign rdata_a = 32'hA5A5_0000 + {27'd0, raddr_a};

  rf_dump_reader #(.FIRST_IDX(0), .LAST_IDX(31)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .rf_raddr(raddr_a), .rf_rdata(rdata_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_data(data_a), .out_idx(idx_a),
    .busy(busy_a), .done(done_a));

  // instance B: 5..7
  logic        start_b = 0, abort_b = 0, ready_b = 0;
  logic [4:0]  raddr_b, idx_b;
  logic [31:0] rdata_b, data_b;
  logic        valid_b, busy_b, done_b;
  assign rdata_b = 32'hA5A5_0000 + {27'd0, raddr_b};

  rf_dump_reader #(.FIRST_IDX(5), .LAST_IDX(7)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .rf_raddr(raddr_b), .rf_rdata(rdata_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_data(data_b), .out_idx(idx_b),
    .busy(busy_b), .done(done_b));

  // instance C: 31..31
  logic        start_c = 0, abort_c = 0, ready_c = 1;
  logic [4:0]  raddr_c, idx_c;
  logic [31:0] rdata_c, data_c;
  logic        valid_c, busy_c, done_c;
  assign rdata_c = 32'hA5A5_0000 + {27'd0, raddr_c};

  rf_dump_reader #(.FIRST_IDX(31), .LAST_IDX(31)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
    .rf_raddr(raddr_c), .rf_rdata(rdata_c), .out_valid(valid_c),
    .out_ready(ready_c), .out_data(data_c), .out_idx(idx_c),
    .busy(busy_c), .done(done_c));

  // Full dump on A with ready held high. With spam set, start stays
  // high for as long as the block is busy.
  task automatic run_full(input bit spam);
    int k = 0, dones = 0, last_hs = -1, done_cyc = -1;
    ready_a = 1;
    @(negedge clk);
    start_a = 1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      start_a = spam && busy_a;
      if (valid_a) begin
        chk($sformatf("full_idx%0d", k), {27'd0, idx_a}, k);
        chk($sformatf("full_data%0d", k), data_a, 32'hA5A5_0000 + k);
        chk($sformatf("full_cyc%0d", k), cyc, 1 + 2 * k);
        k++;
        last_hs = cyc;
      end
      if (done_a) begin
        dones++;
        done_cyc = cyc;
      end
      if (dones > 0 && cyc > done_cyc + 4) break;
    end
    start_a = 0;
    chk("full_words", k, 32);
    chk("full_dones", dones, 1);
    chk("full_done_gap",
        {31'd0, (done_cyc - last_hs >= 1) && (done_cyc - last_hs <= 2)}, 1);
    chk("full_idle_raddr", {27'd0, raddr_a}, 0);
  endtask

  initial begin
    int k, dones, got;
    bit seen;

    #12;
    chk("rst_valid", {31'd0, valid_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_data", data_a, 0);
    chk("rst_idx", {27'd0, idx_a}, 0);
    chk("rst_raddr_b", {27'd0, raddr_b}, 5);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_full(1'b0);
    repeat (2) @(negedge clk);
    run_full(1'b1);

    // stalled window on B
    @(negedge clk);
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (valid_b) seen = 1;
      else @(negedge clk);
    end
    chk("stall_reach", {31'd0, seen}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'd0, valid_b}, 1);
      chk("stall_data", data_b, 32'hA5A5_0005);
      chk("stall_idx", {27'd0, idx_b}, 5);
      chk("stall_raddr", {27'd0, raddr_b}, 5);
      @(negedge clk);
    end
    ready_b = 1;
    k = 0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_b) begin
        chk("win_idx", {27'd0, idx_b}, 5 + k);
        chk("win_data", data_b, 32'hA5A5_0005 + k);
        k++;
      end
      if (done_b) dones++;
      @(negedge clk);
    end
    chk("win_words", k, 3);
    chk("win_dones", dones, 1);
    chk("win_idle_raddr", {27'd0, raddr_b}, 5);

    // abort on A while presenting idx 3, ready high in the same cycle
    ready_a = 1;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    got = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (valid_a && idx_a == 5'd3) begin
        abort_a = 1;
        seen = 1;
      end else if (valid_a) begin
        got++;
      end
    end
    chk("abort_reach", {31'd0, seen}, 1);
    chk("abort_prior", got, 3);
    @(negedge clk);
    abort_a = 0;
    chk("abort_busy", {31'd0, busy_a}, 0);
    chk("abort_valid", {31'd0, valid_a}, 0);
    chk("abort_raddr", {27'd0, raddr_a}, 0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_a || busy_a) dones++;
      @(negedge clk);
    end
    chk("abort_quiet", dones, 0);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (valid_a) seen = 1;
    end
    chk("restart_valid", {31'd0, seen}, 1);
    chk("restart_idx", {27'd0, idx_a}, 0);
    chk("restart_data", data_a, 32'hA5A5_0000);
    ready_a = 0;

    // async reset while A is in READ
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ready_a = 1;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("rr_in_read", {31'd0, busy_a && !valid_a}, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rr_valid", {31'd0, valid_a}, 0);
    chk("rr_busy", {31'd0, busy_a}, 0);
    chk("rr_done", {31'd0, done_a}, 0);
    chk("rr_data", data_a, 0);
    chk("rr_idx", {27'd0, idx_a}, 0);
    chk("rr_raddr", {27'd0, raddr_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy_a || valid_a || done_a) dones++;
    end
    chk("rr_quiet", dones, 0);

    // single-word window at the top index on C
    start_c = 1;
    @(negedge clk);
    start_c = 0;
    k = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_c) begin
        chk("top_idx", {27'd0, idx_c}, 31);
        chk("top_data", data_c, 32'hA5A5_001F);
        k++;
      end
      if (done_c) dones++;
    end
    chk("top_words", k, 1);
    chk("top_dones", dones, 1);
    chk("top_raddr", {27'd0, raddr_c}, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
